// File: rtl/ob_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ob_read_ctrl
// Description : Read-side packet controller for the output buffer FIFO.
//               Drains the FIFO into framed packets (length header, data,
//               optional XOR checksum trailer) over a registered valid/ready
//               output stage.
// Options     : OB_CHECKSUM_EN - append an XOR checksum trailer byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ob_read_ctrl #(
   parameter int PKT_LEN = 64
) (
   input  logic       r_clk,
   input  logic       n_rst,
   input  logic       empty,
   input  logic [7:0] fifo_rdata,
   input  logic [7:0] fill_count,
   input  logic       flush,
   output logic       r_en,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       tx_sop,
   output logic       tx_eop,
   input  logic       tx_ready,
   output logic       busy,
   output logic [7:0] pkt_count
);

   localparam logic [7:0] LEN_FULL = 8'(PKT_LEN);

`ifdef OB_CHECKSUM_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CHK  = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;
`endif

   state_t     state;
   state_t     state_n;
   logic [7:0] remaining;
   logic [7:0] remaining_n;
   logic [7:0] data_n;
   logic       valid_n;
   logic       sop_n;
   logic       eop_n;
   logic       pop;
   logic       slot_free;
   logic       start_full;
   logic       start_flush;
`ifdef OB_CHECKSUM_EN
   logic [7:0] chk;
   logic [7:0] chk_n;
`endif

   // The output register may be overwritten when empty or being accepted now.
   assign slot_free   = !tx_valid || tx_ready;
   assign start_full  = (fill_count >= LEN_FULL);
   assign start_flush = flush && (fill_count != 8'd0);

   // Next-state, next-output-register and FIFO pop decode.
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      data_n      = tx_data;
      valid_n     = tx_valid;
      sop_n       = tx_sop;
      eop_n       = tx_eop;
      pop         = 1'b0;
`ifdef OB_CHECKSUM_EN
      chk_n       = chk;
`endif
      if (slot_free) begin
         // Slot drains unless something is loaded below.
         valid_n = 1'b0;
         case (state)
            IDLE: begin
               if (start_full || start_flush) begin
                  // Full-packet length wins over a flush request.
                  data_n      = start_full ? LEN_FULL : fill_count;
                  valid_n     = 1'b1;
                  sop_n       = 1'b1;
                  eop_n       = 1'b0;
                  remaining_n = data_n;
`ifdef OB_CHECKSUM_EN
                  chk_n       = data_n;
`endif
                  state_n     = DATA;
               end
            end
            DATA: begin
               // An empty FIFO stalls the packet without popping.
               if (!empty) begin
                  pop         = 1'b1;
                  data_n      = fifo_rdata;
                  valid_n     = 1'b1;
                  sop_n       = 1'b0;
                  remaining_n = remaining - 8'd1;
`ifdef OB_CHECKSUM_EN
                  eop_n       = 1'b0;
                  chk_n       = chk ^ fifo_rdata;
                  if (remaining == 8'd1) begin
                     state_n = CHK;
                  end
`else
                  eop_n       = (remaining == 8'd1);
                  if (remaining == 8'd1) begin
                     state_n = IDLE;
                  end
`endif
               end
            end
`ifdef OB_CHECKSUM_EN
            CHK: begin
               data_n  = chk;
               valid_n = 1'b1;
               sop_n   = 1'b0;
               eop_n   = 1'b1;
               state_n = IDLE;
            end
`endif
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Pop is suppressed while reset is asserted.
   assign r_en = pop && n_rst;
   assign busy = (state != IDLE) || tx_valid;

   // State, counters and registered output stage.
   always_ff @(posedge r_clk) begin
      if (!n_rst) begin
         state     <= IDLE;
         remaining <= 8'd0;
         tx_data   <= 8'd0;
         tx_valid  <= 1'b0;
         tx_sop    <= 1'b0;
         tx_eop    <= 1'b0;
`ifdef OB_CHECKSUM_EN
         chk       <= 8'd0;
`endif
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         tx_data   <= data_n;
         tx_valid  <= valid_n;
         tx_sop    <= sop_n;
         tx_eop    <= eop_n;
`ifdef OB_CHECKSUM_EN
         chk       <= chk_n;
`endif
      end
   end

   // Count packets whose final byte the transmitter has accepted.
   always_ff @(posedge r_clk) begin
      if (!n_rst) begin
         pkt_count <= 8'd0;
      end else if (tx_valid && tx_ready && tx_eop) begin
         pkt_count <= pkt_count + 8'd1;
      end
   end

endmodule
`default_nettype wire
